// File: rtl/main_ctrl_fsm_if.sv
// Control bundle between the multicycle main controller and the datapath/FPU.
// master = controller side (reads instruction fields and FPU status, drives controls).
// slave  = datapath side (drives instruction fields and FPU status, reads controls).
interface main_ctrl_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       FpuDone;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       ALUOp;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       FpuW;
  logic       Branch;
  logic       FpuStart;
  logic       FpuTimeout;
  logic [3:0] State;

  modport master (
    input  Op, Funct, FpuDone,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC,
           RegW, MemW, FpuW, Branch, FpuStart, FpuTimeout, State
  );

  modport slave (
    output Op, Funct, FpuDone,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC,
           RegW, MemW, FpuW, Branch, FpuStart, FpuTimeout, State
  );
endinterface

// File: rtl/main_ctrl_fsm.sv
// Multicycle main controller: fetch/decode/execute/writeback sequencing with a
// bounded start/done handshake to a multicycle FPU.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction, PC <- PC+4
// DECODE    | read registers, dispatch on Op
// MEMADR    | compute load/store address
// MEMRD     | read data memory
// MEMWB     | write loaded data to register file
// MEMWR     | write data memory
// EXECR     | ALU op with register operand
// EXECI     | ALU op with immediate operand
// ALUWB     | write ALU result to register file
// BRANCH    | branch target to PC
// FPUSTART  | launch FPU (one-cycle pulse)
// FPUWAIT   | wait for FpuDone, bounded by FPU_TIMEOUT cycles
// FPUWB     | write FPU result
// UNKNOWN   | illegal encoding reached, held until reset
module main_ctrl_fsm #(
  parameter int FPU_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic            clk,
  input  logic            reset,
  main_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_FPUSTART = 4'd10,
    S_FPUWAIT  = 4'd11,
    S_FPUWB    = 4'd12,
    S_UNKNOWN  = 4'd15
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FPU_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fpu_timeout;
  logic             w_timeout_hit;
  logic             w_unused_funct;

  // Funct bits other than I and L belong to the ALU decoder, not to this FSM.
  assign w_unused_funct = ^bus.Funct[4:1];

  // Wait expired this cycle without a result; FpuDone wins if both coincide.
  assign w_timeout_hit = (r_state == S_FPUWAIT) && !bus.FpuDone && (r_cnt == C_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // FPU wait counter (cleared while launching, so it starts at 0 in FPUWAIT) and timeout pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_fpu_timeout <= 1'b0;
    end else begin
      r_fpu_timeout <= w_timeout_hit;
      if (r_state == S_FPUSTART)     r_cnt <= '0;
      else if (r_state == S_FPUWAIT) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = S_UNKNOWN;
    case (r_state)
      S_FETCH:    w_next_state = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          2'b00:   w_next_state = bus.Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next_state = S_MEMADR;
          2'b10:   w_next_state = S_BRANCH;
          default: w_next_state = S_FPUSTART;
        endcase
      end
      S_MEMADR:   w_next_state = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next_state = S_MEMWB;
      S_EXECR,
      S_EXECI:    w_next_state = S_ALUWB;
      S_FPUSTART: w_next_state = S_FPUWAIT;
      S_FPUWAIT: begin
        if (bus.FpuDone)        w_next_state = S_FPUWB;
        else if (w_timeout_hit) w_next_state = S_FETCH;
        else                    w_next_state = S_FPUWAIT;
      end
      S_ALUWB,
      S_MEMWB,
      S_MEMWR,
      S_BRANCH,
      S_FPUWB:    w_next_state = S_FETCH;
      default:    w_next_state = S_UNKNOWN;
    endcase
  end

  // Moore output decode from the current state.
  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ALUOp     = 1'b0;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.FpuW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.FpuStart  = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.NextPC    = 1'b1;
      end
      S_DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_EXECR: begin
        bus.ALUSrcB = 2'b00;
        bus.ALUOp   = 1'b1;
      end
      S_EXECI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
      end
      S_MEMADR:  bus.ALUSrcB = 2'b01;
      S_ALUWB: begin
        bus.ResultSrc = 2'b00;
        bus.RegW      = 1'b1;
      end
      S_MEMRD:   bus.AdrSrc = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
      end
      S_MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.Branch    = 1'b1;
      end
      S_FPUSTART: bus.FpuStart = 1'b1;
      S_FPUWB: begin
        bus.ResultSrc = 2'b00;
        bus.FpuW      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.State      = r_state;
  assign bus.FpuTimeout = r_fpu_timeout;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Bench for main_ctrl_fsm: per-instruction expected state traces are built from the
// instruction class and FPU response time, then every cycle's State, control outputs
// and FpuTimeout are compared against a state-indexed output table.
module tb_main_ctrl_fsm;
  localparam int T = 4;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
  localparam int EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9;
  localparam int FPUSTART = 10, FPUWAIT = 11, FPUWB = 12;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic pend_to = 1'b0;

  always #5 clk = ~clk;

  main_ctrl_fsm_if bus ();

  main_ctrl_fsm #(.FPU_TIMEOUT(T), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [15:0] exp_ctrl(input int s);
    logic ir = 0, adr = 0, sa = 0, aop = 0, npc = 0, rw = 0, mw = 0, fw = 0, br = 0, fs = 0;
    logic [1:0] sb = 2'b00, rs = 2'b00;
    case (s)
      FETCH:    begin ir = 1; sa = 1; sb = 2'b10; rs = 2'b10; npc = 1; end
      DECODE:   begin sa = 1; sb = 2'b10; rs = 2'b10; end
      EXECR:    begin sb = 2'b00; aop = 1; end
      EXECI:    begin sb = 2'b01; aop = 1; end
      MEMADR:   sb = 2'b01;
      ALUWB:    begin rs = 2'b00; rw = 1; end
      MEMRD:    adr = 1;
      MEMWB:    begin rs = 2'b01; rw = 1; end
      MEMWR:    begin adr = 1; mw = 1; end
      BRANCH:   begin sb = 2'b01; rs = 2'b10; br = 1; end
      FPUSTART: fs = 1;
      FPUWB:    begin rs = 2'b00; fw = 1; end
      default:  ;
    endcase
    return {2'b00, ir, adr, sa, sb, rs, aop, npc, rw, mw, fw, br, fs};
  endfunction

  function automatic logic [15:0] obs_ctrl();
    return {2'b00, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.ALUOp, bus.NextPC, bus.RegW, bus.MemW, bus.FpuW, bus.Branch, bus.FpuStart};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input int s, input logic to);
    chk($sformatf("state(exp %0d)", s), {12'd0, bus.State}, 16'(s));
    chk($sformatf("ctrl@%0d", s), obs_ctrl(), exp_ctrl(s));
    chk($sformatf("timeout@%0d", s), {15'd0, bus.FpuTimeout}, {15'd0, to});
  endtask

  // d = FPUWAIT cycle (1-based) on which FpuDone is high; d > T means never.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input int d);
    int q[$];
    int k = 0;
    logic to_next = 1'b0;
    q.push_back(FETCH);
    q.push_back(DECODE);
    case (op)
      2'b00: begin q.push_back(funct[5] ? EXECI : EXECR); q.push_back(ALUWB); end
      2'b01: begin
        q.push_back(MEMADR);
        if (funct[0]) begin q.push_back(MEMRD); q.push_back(MEMWB); end
        else q.push_back(MEMWR);
      end
      2'b10: q.push_back(BRANCH);
      default: begin
        q.push_back(FPUSTART);
        for (int w = 0; w < ((d <= T) ? d : T); w++) q.push_back(FPUWAIT);
        if (d <= T) q.push_back(FPUWB);
        else to_next = 1'b1;
      end
    endcase
    for (int i = 0; i < q.size(); i++) begin
      check_cycle(q[i], (i == 0) ? pend_to : 1'b0);
      if (q[i] == FETCH) begin
        bus.Op = op;
        bus.Funct = funct;
      end else if (i == q.size() - 1) begin
        bus.Op = 2'($urandom);
        bus.Funct = 6'($urandom);
      end
      if (q[i] == FPUWAIT) begin
        k++;
        bus.FpuDone = (k == d);
      end else begin
        bus.FpuDone = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    pend_to = to_next;
  endtask

  initial begin
    reset = 1'b1;
    bus.Op = 2'b11;
    bus.Funct = 6'h3f;
    bus.FpuDone = 1'b1;
    #3;
    check_cycle(FETCH, 1'b0);
    @(negedge clk);
    check_cycle(FETCH, 1'b0);
    reset = 1'b0;

    run_instr(2'b00, 6'b011110, 0);   // DP register
    run_instr(2'b00, 6'b100001, 0);   // DP immediate
    run_instr(2'b01, 6'b000001, 0);   // LDR
    run_instr(2'b01, 6'b100000, 0);   // STR
    run_instr(2'b10, 6'b010101, 0);   // B
    run_instr(2'b11, 6'b000000, 3);   // FPU done on 3rd wait cycle
    run_instr(2'b11, 6'b000000, 99);  // FPU timeout
    run_instr(2'b11, 6'b111111, T);   // FpuDone on the timeout cycle
    run_instr(2'b00, 6'b000000, 0);

    // Reset asserted asynchronously in the middle of a store's MEMWR cycle.
    check_cycle(FETCH, pend_to);
    bus.Op = 2'b01;
    bus.Funct = 6'b000000;
    bus.FpuDone = 1'b0;
    @(negedge clk);
    check_cycle(DECODE, 1'b0);
    @(negedge clk);
    check_cycle(MEMADR, 1'b0);
    @(negedge clk);
    check_cycle(MEMWR, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rst_memw", {15'd0, bus.MemW}, 16'd0);
    chk("rst_state", {12'd0, bus.State}, 16'd0);
    chk("rst_ctrl", obs_ctrl(), exp_ctrl(FETCH));
    @(negedge clk);
    check_cycle(FETCH, 1'b0);
    reset = 1'b0;
    pend_to = 1'b0;

    for (int n = 0; n < 60; n++) begin
      run_instr(2'($urandom), 6'($urandom), int'($urandom_range(1, T + 2)));
    end
    check_cycle(FETCH, pend_to);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
